result_formatter: RTL and testbench
===================================

# result_formatter

Result-to-text serializer on the output end of the RPN datapath. It accepts each 32-bit signed result from the calculator over the stb/ack word handshake and renders it as ASCII decimal: an optional '-', the digits without leading zeros, then a terminator byte. Bytes leave one at a time over a byte-wide stb/ack stream toward the host or UART side. It is the synthesizable counterpart of the token scanner that feeds the converter.

## Interface
- TERM_CHAR, 8'h0A: terminator byte emitted after the digits.
- EMIT_TERM, 1: 1 means emit TERM_CHAR after each number; 0 means omit it.
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  reset, asynchronous, active-low. Asserting it forces all state and outputs to reset values immediately.
- input_stb  in  1  upstream result valid.
- input_data  in  32  two's-complement result; held stable while input_stb=1.
- input_ack  out  1  one-cycle pulse: word captured.
- output_stb  out  1  output_data holds a valid character.
- output_data  out  8  ASCII character.
- output_ack  in  1  downstream consumed the character at this edge.

## Operation
- States: IDLE, CONVERT, EMIT.
- IDLE, input_stb=1 at edge E0:
  - Capture the sign, and the magnitude as unsigned 32-bit (0 - x when negative). -2147483648 therefore gives magnitude 2147483648.
  - Clear the 40-bit BCD register and the shift counter.
  - input_ack=1 for exactly cycle E0..E1.
  - Go to CONVERT.
- CONVERT: double-dabble, one bit per cycle, 32 cycles.
  - Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd, mag} left by 1.
  - On the 32nd shift:
    - Compute the most-significant nonzero digit index with a priority encoder. If all digits are zero, use index 0, which yields "0".
    - Build the character sequence: '-' (8'h2D) if sign=1, then digits as 8'h30+d from MS nonzero digit down to digit 0, then TERM_CHAR if EMIT_TERM=1.
    - Go to EMIT.
- EMIT: present the characters one at a time.
  - Advance to the next character on each edge where output_stb=1 and output_ack=1.
  - After the last character is accepted, go to IDLE.
- Maximum sequence length is 12 bytes ('-', 10 digits, terminator). Minimum is 1 byte (digit 0, EMIT_TERM=0).
- input_stb is ignored in CONVERT and EMIT. No ack is given and nothing is captured; upstream stays stalled.
- output_ack while output_stb=0 is ignored.

## Timing
- Reset values: input_ack=0, output_stb=0, output_data=8'h00, state IDLE, counters 0.
- Handshake, upstream:
  - Upstream holds input_stb and input_data until it sees input_ack, then drops input_stb.
  - The block is busy for at least 33 cycles after capture, so a held stb is never captured twice.
- Handshake, downstream:
  - output_data and output_stb are stable while output_stb=1 and output_ack=0, i.e. under backpressure for any number of cycles.
  - With output_ack held high, one character transfers per cycle and output_stb stays high between characters.
- Latency:
  - Capture at edge E0; the first character is valid after edge E0+32.
  - Total time to IDLE is 32 + N cycles with no backpressure (N = number of characters).
- After the last transfer edge, output_stb=0 in the following cycle and the block is in IDLE. The earliest next capture is the next edge.
- Reset mid-operation: the partial string is abandoned and outputs return to reset values asynchronously. After RST deasserts, the block waits in IDLE for a fresh input_stb.

## Test plan
- 0 -> output_stb rises 32 cycles after the capture edge; bytes 30 0A; then IDLE with output_stb=0.
- 12345 with output_ack tied high -> 31 32 33 34 35 0A on consecutive cycles; input_ack is exactly one cycle wide.
- -7, then 2147483647, then -2147483648 back-to-back -> 2D 37 0A; 32 31 34 37 34 38 33 36 34 37 0A; 2D 32 31 34 37 34 38 33 36 34 38 0A. The second and third words are not acked until the previous string completes.
- Backpressure: 905 with output_ack low 5 cycles before each byte -> 39 30 35 0A, each byte stable for 6 cycles; no byte lost or duplicated.
- EMIT_TERM=0, input 100 -> 31 30 30 only; output_stb drops after the third transfer.
- RST asserted after the second byte of -4096 -> outputs zero immediately. After release, 42 yields 34 32 0A with no stale characters.

Source files
------------

// File: rtl/result_formatter_if.sv
// result_formatter_if: word-in / byte-out stb/ack bundle.
// slave = formatter side, master = upstream + downstream side.
//
// Signals:
//   input_stb/input_data/input_ack    32-bit signed result handshake
//   output_stb/output_data/output_ack ASCII byte stream handshake
interface result_formatter_if;

    logic        input_stb;
    logic [31:0] input_data;
    logic        input_ack;
    logic        output_stb;
    logic [7:0]  output_data;
    logic        output_ack;

    modport slave (
        input  input_stb,
        input  input_data,
        input  output_ack,
        output input_ack,
        output output_stb,
        output output_data
    );

    modport master (
        output input_stb,
        output input_data,
        output output_ack,
        input  input_ack,
        input  output_stb,
        input  output_data
    );

endinterface

// File: rtl/result_formatter.sv
// result_formatter: renders a 32-bit signed result as ASCII decimal
// ('-', digits without leading zeros, optional terminator) on a byte stream.
//
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous active-low reset
//   bus      result_formatter_if.slave
//            input_stb/input_data/input_ack    : word capture handshake
//            output_stb/output_data/output_ack : character stream
// Parameters:
//   TERM_CHAR  terminator byte appended after the digits
//   EMIT_TERM  1 = append TERM_CHAR, 0 = digits only
module result_formatter #(
    parameter logic [7:0] TERM_CHAR = 8'h0A,
    parameter bit         EMIT_TERM = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    result_formatter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        EMIT
    } state_t;

    // registered state
    state_t      r_state;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [39:0] r_bcd;
    logic [4:0]  r_cnt;
    logic [3:0]  r_len;
    logic [3:0]  r_idx;
    logic [7:0]  r_buf [12];
    logic        r_in_ack;
    logic        r_out_stb;
    logic [7:0]  r_out_data;

    // next-state values
    state_t      w_state_nxt;
    logic        w_sign_nxt;
    logic [31:0] w_mag_nxt;
    logic [39:0] w_bcd_nxt;
    logic [4:0]  w_cnt_nxt;
    logic [3:0]  w_len_nxt;
    logic [3:0]  w_idx_nxt;
    logic        w_load;
    logic        w_in_ack_nxt;
    logic        w_out_stb_nxt;
    logic [7:0]  w_out_data_nxt;

    // double-dabble datapath
    logic [39:0] w_bcd_adj;
    logic [39:0] w_bcd_shift;
    logic [31:0] w_mag_shift;

    // character sequence builder
    logic [3:0]  w_msd;
    logic [3:0]  w_k;
    logic [3:0]  w_nd;
    logic [3:0]  w_len;
    logic [3:0]  w_pos;
    logic [3:0]  w_dig;
    logic [7:0]  w_seq [12];

    assign bus.input_ack   = r_in_ack;
    assign bus.output_stb  = r_out_stb;
    assign bus.output_data = r_out_data;

    // One double-dabble step: correct nibbles >=5, then shift {bcd, mag}.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < 10; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        {w_bcd_shift, w_mag_shift} = {w_bcd_adj, r_mag} << 1;
    end

    // Build the string from the BCD value produced by the final shift.
    // The highest nonzero nibble wins; all-zero leaves index 0 -> "0".
    always_comb begin
        w_msd = 4'd0;
        for (int d = 0; d < 10; d++) begin
            if (w_bcd_shift[4*d +: 4] != 4'd0) begin
                w_msd = 4'(d);
            end
        end
        w_k   = {3'b000, r_sign};
        w_nd  = w_msd + 4'd1;
        w_len = w_k + w_nd + (EMIT_TERM ? 4'd1 : 4'd0);
        w_pos = 4'd0;
        w_dig = 4'd0;
        for (int i = 0; i < 12; i++) begin
            w_pos    = 4'(i);
            w_dig    = 4'd0;
            w_seq[i] = 8'h00;
            if (w_pos < w_k) begin
                w_seq[i] = 8'h2D;
            end else if ((w_pos - w_k) < w_nd) begin
                w_dig    = w_msd - (w_pos - w_k);
                w_seq[i] = 8'h30 + {4'h0, w_bcd_shift[{w_dig, 2'b00} +: 4]};
            end else if (EMIT_TERM && ((w_pos - w_k) == w_nd)) begin
                w_seq[i] = TERM_CHAR;
            end
        end
    end

    // FSM next-state and outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_sign_nxt     = r_sign;
        w_mag_nxt      = r_mag;
        w_bcd_nxt      = r_bcd;
        w_cnt_nxt      = r_cnt;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_load         = 1'b0;
        w_in_ack_nxt   = 1'b0;
        w_out_stb_nxt  = r_out_stb;
        w_out_data_nxt = r_out_data;

        unique case (r_state)
            IDLE: begin
                if (bus.input_stb) begin
                    w_sign_nxt   = bus.input_data[31];
                    w_mag_nxt    = bus.input_data[31]
                                 ? (32'd0 - bus.input_data)
                                 : bus.input_data;
                    w_bcd_nxt    = 40'd0;
                    w_cnt_nxt    = 5'd0;
                    w_in_ack_nxt = 1'b1;
                    w_state_nxt  = CONVERT;
                end
            end

            CONVERT: begin
                w_bcd_nxt = w_bcd_shift;
                w_mag_nxt = w_mag_shift;
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_load         = 1'b1;
                    w_len_nxt      = w_len;
                    w_idx_nxt      = 4'd0;
                    w_out_stb_nxt  = 1'b1;
                    w_out_data_nxt = w_seq[0];
                    w_state_nxt    = EMIT;
                end
            end

            EMIT: begin
                if (r_out_stb && bus.output_ack) begin
                    if ((r_idx + 4'd1) == r_len) begin
                        w_out_stb_nxt  = 1'b0;
                        w_out_data_nxt = 8'h00;
                        w_idx_nxt      = 4'd0;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_idx_nxt      = r_idx + 4'd1;
                        w_out_data_nxt = r_buf[r_idx + 4'd1];
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_mag      <= 32'd0;
            r_bcd      <= 40'd0;
            r_cnt      <= 5'd0;
            r_len      <= 4'd0;
            r_idx      <= 4'd0;
            r_in_ack   <= 1'b0;
            r_out_stb  <= 1'b0;
            r_out_data <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_sign     <= w_sign_nxt;
            r_mag      <= w_mag_nxt;
            r_bcd      <= w_bcd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_in_ack   <= w_in_ack_nxt;
            r_out_stb  <= w_out_stb_nxt;
            r_out_data <= w_out_data_nxt;
        end
    end

    // character buffer, loaded once per number
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 12; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_load) begin
            for (int i = 0; i < 12; i++) begin
                r_buf[i] <= w_seq[i];
            end
        end
    end

endmodule

// File: tb/tb_result_formatter.sv
// tb_result_formatter: directed checks of result_formatter.
// Two instances: default terminator on, and EMIT_TERM=0.
module tb_result_formatter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_stb = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ack = 1'b0;
    logic        sel = 1'b0;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;
    int lat;
    int a0;

    logic [7:0] exp_q [$];

    result_formatter_if bus ();
    result_formatter_if bus_nt ();

    assign bus.input_stb     = in_stb & ~sel;
    assign bus.input_data    = in_data;
    assign bus.output_ack    = out_ack;
    assign bus_nt.input_stb  = in_stb & sel;
    assign bus_nt.input_data = in_data;
    assign bus_nt.output_ack = out_ack;

    logic       w_stb;
    logic [7:0] w_data;
    logic       w_ack;

    assign w_stb  = sel ? bus_nt.output_stb  : bus.output_stb;
    assign w_data = sel ? bus_nt.output_data : bus.output_data;
    assign w_ack  = sel ? bus_nt.input_ack   : bus.input_ack;

    result_formatter #(
        .TERM_CHAR(8'h0A),
        .EMIT_TERM(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    result_formatter #(
        .TERM_CHAR(8'h0A),
        .EMIT_TERM(1'b0)
    ) dut_nt (
        .CLK(CLK),
        .RST(RST),
        .bus(bus_nt.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bus.input_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input logic [31:0] d);
        in_data = d;
        in_stb  = 1'b1;
    endtask

    // Wait for the capture pulse, drop stb, confirm the pulse is one cycle.
    task automatic wait_ack();
        int w;
        w = 0;
        while (!w_ack && w < 200) begin
            tick();
            w++;
        end
        check("ack_seen", w_ack, 1);
        in_stb = 1'b0;
        tick();
        check("ack_pulse", w_ack, 0);
    endtask

    task automatic send(input logic [31:0] d);
        raise(d);
        wait_ack();
    endtask

    // Receive exp_q; bp = cycles of ack-low backpressure per byte.
    task automatic recv(input int bp, input bit chk_drop);
        int w;
        for (int i = 0; i < exp_q.size(); i++) begin
            w = 0;
            while (!w_stb && w < 100) begin
                tick();
                w++;
            end
            if (!w_stb) begin
                check("stb_timeout", w_stb, 1);
                out_ack = 1'b0;
                return;
            end
            if (bp == 0 && i > 0) check("gap", w, 0);
            check($sformatf("byte%0d", i), w_data, exp_q[i]);
            if (bp > 0) begin
                out_ack = 1'b0;
                for (int c = 0; c < bp; c++) begin
                    tick();
                    check("hold_stb", w_stb, 1);
                    check("hold_data", w_data, exp_q[i]);
                end
            end
            out_ack = 1'b1;
            tick();
        end
        if (chk_drop) check("stb_drop", w_stb, 0);
    endtask

    initial begin
        // reset values
        tick();
        tick();
        check("rst_stb", bus.output_stb, 0);
        check("rst_data", bus.output_data, 8'h00);
        check("rst_ack", bus.input_ack, 0);
        check("rst_nt_stb", bus_nt.output_stb, 0);
        RST = 1'b1;
        tick();

        // 0: latency and "0\n"
        send(32'd0);
        lat = 0;
        while (!w_stb && lat < 40) begin
            tick();
            lat++;
        end
        check("lat_zero", lat, 31);
        exp_q = '{8'h30, 8'h0A};
        recv(0, 1'b1);

        // 12345 with ack tied high
        out_ack = 1'b1;
        send(32'd12345);
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0A};
        recv(0, 1'b1);

        // back-to-back -7, 2147483647, -2147483648
        send(32'hFFFF_FFF9);
        tick();
        raise(32'h7FFF_FFFF);
        a0 = ack_cnt;
        exp_q = '{8'h2D, 8'h37, 8'h0A};
        recv(0, 1'b1);
        check("no_early_ack1", ack_cnt, a0);
        wait_ack();
        tick();
        raise(32'h8000_0000);
        a0 = ack_cnt;
        exp_q = '{8'h32, 8'h31, 8'h34, 8'h37, 8'h34,
                  8'h38, 8'h33, 8'h36, 8'h34, 8'h37, 8'h0A};
        recv(0, 1'b1);
        check("no_early_ack2", ack_cnt, a0);
        wait_ack();
        exp_q = '{8'h2D, 8'h32, 8'h31, 8'h34, 8'h37, 8'h34,
                  8'h38, 8'h33, 8'h36, 8'h34, 8'h38, 8'h0A};
        recv(0, 1'b1);

        // backpressure: 905
        out_ack = 1'b0;
        send(32'd905);
        exp_q = '{8'h39, 8'h30, 8'h35, 8'h0A};
        recv(5, 1'b1);

        // no terminator: 100
        out_ack = 1'b0;
        sel = 1'b1;
        send(32'd100);
        exp_q = '{8'h31, 8'h30, 8'h30};
        recv(0, 1'b1);
        sel = 1'b0;

        // reset during -4096 after two bytes
        out_ack = 1'b0;
        send(32'hFFFF_F000);
        exp_q = '{8'h2D, 8'h34};
        recv(0, 1'b0);
        check("pre_rst_byte", w_data, 8'h30);
        out_ack = 1'b0;
        RST = 1'b0;
        #2;
        check("async_stb", bus.output_stb, 0);
        check("async_data", bus.output_data, 8'h00);
        check("async_ack", bus.input_ack, 0);
        tick();
        tick();
        check("rst_hold_stb", bus.output_stb, 0);
        RST = 1'b1;
        tick();
        tick();
        check("post_rst_idle", bus.output_stb, 0);
        send(32'd42);
        exp_q = '{8'h34, 8'h32, 8'h0A};
        recv(0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
